fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-RAM read port and the instruction output
// handshake of fetch_unit into one interface.
//   master: the fetch unit (drives address/strobe and the instruction stream)
//   slave : the RAM plus consumer side (drives read data and inst_ready)
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-3:0] mem_addr;
  logic            mem_re;
  logic [31:0]     mem_rdata;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;

  modport master (
    output mem_addr, mem_re, inst, inst_pc, inst_valid,
    input  mem_rdata, inst_ready
  );

  modport slave (
    input  mem_addr, mem_re, inst, inst_pc, inst_valid,
    output mem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch.
// One read is issued per instruction (FETCH), the fixed-latency RAM result
// is awaited (WAIT), then held on a valid/ready handshake (VALID). A redirect
// restarts fetching at a new word-aligned PC and discards any fetch in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined  : a redirect to a non-word-aligned target sets the sticky
//              misalign flag and parks the unit in HALT until reset.
//   undefined: the two low target bits are ignored, misalign stays 0.
module fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [31:0]     fetch_count,
  output logic            misalign,
  fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  // Wait counter start value: the counter reaches zero in exactly the cycle
  // the RAM presents the data, MEM_LATENCY cycles after the read strobe.
  localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [1:0]      wait_cnt;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            inst_valid_q;
  logic            mem_re_q;
  logic [31:0]     fetch_count_q;
  logic            misalign_q;

  logic            handshake;
  logic            trap_hit;
  logic            take_redirect;

  // An instruction is consumed when it is offered and accepted together.
  assign handshake = (state == S_VALID) && inst_valid_q && bus.inst_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A redirect that does not land on a word boundary traps instead of fetching.
  assign trap_hit = redirect && (redirect_target[1:0] != 2'b00);
`else
  // Low target bits carry no meaning when trapping is compiled out.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];
  assign trap_hit           = 1'b0;
`endif

  // HALT is deaf to redirects; everywhere else a redirect overrides the FSM.
  assign take_redirect = redirect && (state != S_HALT);

  // Fetch FSM with all outputs registered alongside the state.
  // NOTE: every assignment to state in a clocked block is non-blocking, so all
  // flops sample the same pre-edge values no matter the statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      wait_cnt      <= '0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      mem_re_q      <= 1'b0;
      fetch_count_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      // Every accepted instruction is counted, even if a redirect coincides.
      if (handshake) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end

      if (take_redirect) begin
        // Whatever was pending (a read in flight or an offered instruction)
        // is abandoned; the late read data never reaches inst.
        inst_valid_q <= 1'b0;
        wait_cnt     <= '0;
        if (trap_hit) begin
          misalign_q <= 1'b1;
          mem_re_q   <= 1'b0;
          state      <= S_HALT;
        end else begin
          pc       <= {redirect_target[XLEN-1:2], 2'b00};
          mem_re_q <= 1'b1;
          state    <= S_FETCH;
        end
      end else begin
        case (state)
          S_FETCH: begin
            if (!mem_re_q) begin
              // First cycle out of reset: the strobe is not up yet, so the
              // issue cycle is the next one.
              mem_re_q <= 1'b1;
            end else begin
              mem_re_q <= 1'b0;
              wait_cnt <= WAIT_INIT;
              state    <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (wait_cnt != 2'd0) begin
              wait_cnt <= wait_cnt - 2'd1;
            end else begin
              inst_q       <= bus.mem_rdata;
              inst_pc_q    <= pc;
              inst_valid_q <= 1'b1;
              state        <= S_VALID;
            end
          end

          S_VALID: begin
            // inst/inst_pc stay frozen until the consumer takes them.
            if (handshake) begin
              pc           <= pc + XLEN'(4);
              inst_valid_q <= 1'b0;
              mem_re_q     <= 1'b1;
              state        <= S_FETCH;
            end
          end

          S_HALT: begin
            // Parked until reset: no reads, nothing offered.
            mem_re_q     <= 1'b0;
            inst_valid_q <= 1'b0;
          end

          default: begin
            state <= S_FETCH;
          end
        endcase
      end
    end
  end

  // Output mapping; the word address follows the current PC directly.
  assign bus.mem_addr   = pc[XLEN-1:2];
  assign bus.mem_re     = mem_re_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign fetch_count    = fetch_count_q;
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Three instances: d1 (XLEN 32, latency 1), d3 (latency 3) and d8 (XLEN 8,
// reset PC 0xFC). Each has its own reset and a behavioural RAM returning
// 0xA0 + word_address exactly MEM_LATENCY cycles after a strobe and
// 0xDEADBEEF in any other cycle.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- instance d1 ----------------
  logic        rst_n1 = 1'b0;
  logic        redir1 = 1'b0;
  logic [31:0] tgt1   = '0;
  logic        ready1 = 1'b0;
  logic [31:0] cnt1;
  logic        mis1;
  fetch_unit_if #(.XLEN(32)) bus1 ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MEM_LATENCY(1)) u_d1 (
    .clk(clk), .resetn(rst_n1), .redirect(redir1), .redirect_target(tgt1),
    .fetch_count(cnt1), .misalign(mis1), .bus(bus1)
  );

  // ---------------- instance d3 ----------------
  logic        rst_n3 = 1'b0;
  logic        redir3 = 1'b0;
  logic [31:0] tgt3   = '0;
  logic        ready3 = 1'b0;
  logic [31:0] cnt3;
  logic        mis3;
  fetch_unit_if #(.XLEN(32)) bus3 ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MEM_LATENCY(3)) u_d3 (
    .clk(clk), .resetn(rst_n3), .redirect(redir3), .redirect_target(tgt3),
    .fetch_count(cnt3), .misalign(mis3), .bus(bus3)
  );

  // ---------------- instance d8 ----------------
  logic       rst_n8 = 1'b0;
  logic       redir8 = 1'b0;
  logic [7:0] tgt8   = '0;
  logic       ready8 = 1'b0;
  logic [31:0] cnt8;
  logic        mis8;
  fetch_unit_if #(.XLEN(8)) bus8 ();

  fetch_unit #(.XLEN(8), .RESET_PC(8'hFC), .MEM_LATENCY(1)) u_d8 (
    .clk(clk), .resetn(rst_n8), .redirect(redir8), .redirect_target(tgt8),
    .fetch_count(cnt8), .misalign(mis8), .bus(bus8)
  );

  // ---------------- RAM models ----------------
  function automatic logic [31:0] ram_word(input logic [31:0] waddr);
    return 32'hA0 + waddr;
  endfunction

  logic        v1;
  logic [29:0] a1;
  always @(posedge clk) begin
    v1 <= bus1.mem_re;
    a1 <= bus1.mem_addr;
  end
  assign bus1.mem_rdata  = v1 ? ram_word({2'b00, a1}) : 32'hDEADBEEF;
  assign bus1.inst_ready = ready1;

  logic [2:0]  v3;
  logic [29:0] a3 [3];
  always @(posedge clk) begin
    v3    <= {v3[1:0], bus3.mem_re};
    a3[0] <= bus3.mem_addr;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign bus3.mem_rdata  = v3[2] ? ram_word({2'b00, a3[2]}) : 32'hDEADBEEF;
  assign bus3.inst_ready = ready3;

  logic       v8;
  logic [5:0] a8;
  always @(posedge clk) begin
    v8 <= bus8.mem_re;
    a8 <= bus8.mem_addr;
  end
  assign bus8.mem_rdata  = v8 ? ram_word({26'b0, a8}) : 32'hDEADBEEF;
  assign bus8.inst_ready = ready8;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic re, input logic [31:0] addr,
                      input logic vld, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] cnt);
    check({tag, " mem_re"},      bus1.mem_re,     re);
    check({tag, " mem_addr"},    bus1.mem_addr,   addr);
    check({tag, " inst_valid"},  bus1.inst_valid, vld);
    check({tag, " inst"},        bus1.inst,       inst);
    check({tag, " inst_pc"},     bus1.inst_pc,    pc);
    check({tag, " fetch_count"}, cnt1,            cnt);
  endtask

  // One record per d1 cycle: inputs for that cycle and the outputs expected
  // during it.
  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        rdy;
    logic        re;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic redir, input logic [31:0] tgt, input logic rdy,
                              input logic re, input logic [31:0] addr, input logic vld,
                              input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] cnt);
    vec_t v;
    v.redir = redir; v.tgt = tgt; v.rdy = rdy;
    v.re = re; v.addr = addr; v.vld = vld; v.inst = inst; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs [24];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            redir tgt   rdy  re addr  vld inst    pc     cnt
    vecs[0]  = mk(0, 32'h0,  1,   1, 'h00, 0, 32'h00, 32'h00, 0);
    vecs[1]  = mk(0, 32'h0,  1,   0, 'h00, 0, 32'h00, 32'h00, 0);
    vecs[2]  = mk(0, 32'h0,  1,   0, 'h00, 1, 32'hA0, 32'h00, 0);
    vecs[3]  = mk(0, 32'h0,  1,   1, 'h01, 0, 32'hA0, 32'h00, 1);
    vecs[4]  = mk(0, 32'h0,  1,   0, 'h01, 0, 32'hA0, 32'h00, 1);
    vecs[5]  = mk(0, 32'h0,  1,   0, 'h01, 1, 32'hA1, 32'h04, 1);
    vecs[6]  = mk(0, 32'h0,  1,   1, 'h02, 0, 32'hA1, 32'h04, 2);
    vecs[7]  = mk(0, 32'h0,  1,   0, 'h02, 0, 32'hA1, 32'h04, 2);
    vecs[8]  = mk(0, 32'h0,  1,   0, 'h02, 1, 32'hA2, 32'h08, 2);
    vecs[9]  = mk(0, 32'h0,  1,   1, 'h03, 0, 32'hA2, 32'h08, 3);
    vecs[10] = mk(0, 32'h0,  1,   0, 'h03, 0, 32'hA2, 32'h08, 3);
    vecs[11] = mk(0, 32'h0,  1,   0, 'h03, 1, 32'hA3, 32'h0C, 3);
    vecs[12] = mk(0, 32'h0,  1,   1, 'h04, 0, 32'hA3, 32'h0C, 4);
    // redirect to 0x40 while the read of word 4 is waiting
    vecs[13] = mk(1, 32'h40, 1,   0, 'h04, 0, 32'hA3, 32'h0C, 4);
    vecs[14] = mk(0, 32'h0,  1,   1, 'h10, 0, 32'hA3, 32'h0C, 4);
    vecs[15] = mk(0, 32'h0,  1,   0, 'h10, 0, 32'hA3, 32'h0C, 4);
    vecs[16] = mk(0, 32'h0,  1,   0, 'h10, 1, 32'hB0, 32'h40, 4);
    vecs[17] = mk(0, 32'h0,  1,   1, 'h11, 0, 32'hB0, 32'h40, 5);
    vecs[18] = mk(0, 32'h0,  1,   0, 'h11, 0, 32'hB0, 32'h40, 5);
    // redirect to 0x80 in the same cycle as the handshake of pc 0x44
    vecs[19] = mk(1, 32'h80, 1,   0, 'h11, 1, 32'hB1, 32'h44, 5);
    vecs[20] = mk(0, 32'h0,  1,   1, 'h20, 0, 32'hB1, 32'h44, 6);
    vecs[21] = mk(0, 32'h0,  1,   0, 'h20, 0, 32'hB1, 32'h44, 6);
    vecs[22] = mk(0, 32'h0,  0,   0, 'h20, 1, 32'hC0, 32'h80, 6);
    vecs[23] = mk(0, 32'h0,  0,   0, 'h20, 1, 32'hC0, 32'h80, 6);

    // ---- reset state of all instances while reset is held ----
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("reset d1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("reset d1 misalign", mis1, 1'b0);
    check("reset d3 mem_re", bus3.mem_re, 1'b0);
    check("reset d3 inst_valid", bus3.inst_valid, 1'b0);
    check("reset d8 mem_addr", bus8.mem_addr, 32'h3F);
    check("reset d8 inst_pc", bus8.inst_pc, 32'h0);
    rst_n1 = 1'b1;

    // ---- d1 table ----
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      redir1 = vecs[i].redir;
      tgt1   = vecs[i].tgt;
      ready1 = vecs[i].rdy;
      chk1($sformatf("d1 c%0d", i + 1), vecs[i].re, vecs[i].addr, vecs[i].vld,
           vecs[i].inst, vecs[i].pc, vecs[i].cnt);
      @(negedge clk);
    end

    // ---- d1: redirect to a misaligned target (c25 onward) ----
    redir1 = 1'b1;
    tgt1   = 32'h42;
    ready1 = 1'b0;
    chk1("d1 c25", 1'b0, 32'h20, 1'b1, 32'hC0, 32'h80, 32'd6);
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("d1 trap misalign", mis1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      redir1 = 1'b1;
      tgt1   = 32'h0;
      ready1 = 1'b1;
      check($sformatf("d1 halt%0d mem_re", c), bus1.mem_re, 1'b0);
      check($sformatf("d1 halt%0d inst_valid", c), bus1.inst_valid, 1'b0);
      check($sformatf("d1 halt%0d misalign", c), mis1, 1'b1);
      @(negedge clk);
    end
    redir1 = 1'b0;
`else
    redir1 = 1'b0;
    ready1 = 1'b1;
    chk1("d1 c26", 1'b1, 32'h10, 1'b0, 32'hC0, 32'h80, 32'd6);
    check("d1 c26 misalign", mis1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    ready1 = 1'b0;
    chk1("d1 c28", 1'b0, 32'h10, 1'b1, 32'hB0, 32'h40, 32'd6);
    check("d1 c28 misalign", mis1, 1'b0);
    @(negedge clk);
`endif

    // ---- d1: asynchronous reset mid-operation ----
    #2;
    rst_n1 = 1'b0;
    #1;
    chk1("d1 async reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("d1 async reset misalign", mis1, 1'b0);
    @(negedge clk);
    #1;
    rst_n1 = 1'b1;
    ready1 = 1'b1;
    @(negedge clk);
    chk1("d1 post-reset c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk1("d1 post-reset c2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk1("d1 post-reset c3", 1'b0, 32'h0, 1'b1, 32'hA0, 32'h0, 32'h0);

    // ---- d3: latency 3, consumer stalls 5 cycles ----
    #1;
    rst_n3 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 15; c++) begin
      ready3 = (c >= 10);
      check($sformatf("d3 c%0d mem_re", c), bus3.mem_re, (c == 1 || c == 11));
      check($sformatf("d3 c%0d inst_valid", c), bus3.inst_valid,
            ((c >= 5 && c <= 10) || c == 15));
      check($sformatf("d3 c%0d inst", c), bus3.inst,
            (c < 5) ? 32'h0 : (c < 15) ? 32'hA0 : 32'hA1);
      check($sformatf("d3 c%0d inst_pc", c), bus3.inst_pc, (c < 15) ? 32'h0 : 32'h4);
      check($sformatf("d3 c%0d fetch_count", c), cnt3, (c >= 11) ? 32'd1 : 32'd0);
      if (c == 11) check("d3 c11 mem_addr", bus3.mem_addr, 32'h1);
      @(negedge clk);
    end

    // ---- d8: XLEN 8, PC wraps from 0xFC to 0x00 ----
    #1;
    rst_n8 = 1'b1;
    ready8 = 1'b1;
    @(negedge clk);
    check("d8 c1 mem_re", bus8.mem_re, 1'b1);
    check("d8 c1 mem_addr", bus8.mem_addr, 32'h3F);
    @(negedge clk);
    @(negedge clk);
    check("d8 c3 inst_valid", bus8.inst_valid, 1'b1);
    check("d8 c3 inst", bus8.inst, 32'hDF);
    check("d8 c3 inst_pc", bus8.inst_pc, 32'hFC);
    @(negedge clk);
    check("d8 c4 mem_re", bus8.mem_re, 1'b1);
    check("d8 c4 mem_addr", bus8.mem_addr, 32'h0);
    check("d8 c4 fetch_count", cnt8, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("d8 c6 inst_valid", bus8.inst_valid, 1'b1);
    check("d8 c6 inst", bus8.inst, 32'hA0);
    check("d8 c6 inst_pc", bus8.inst_pc, 32'h0);
    check("d8 c6 misalign", mis8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
